// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: TLP header constants, transmitter FSM states and the
// posted-data credit helper shared by the MWr transmitter files.
package pcie_tlp_pkg;

  localparam logic [1:0] FMT_3DW_DATA = 2'b10;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_REQ,
    S_HDR,
    S_DATA
  } tx_state_e;

  // Posted data credits needed for len dwords (16 bytes per credit).
  function automatic logic [11:0] pd_credits(input logic [11:0] len);
    return (len + 12'd3) >> 2;
  endfunction

endpackage

// File: rtl/pcie_pay_fifo.sv
// pcie_pay_fifo: synchronous 32-bit payload FIFO with show-ahead read.
// Ports: clk/rst (sync, active-high), wr/din push, rd pop, dout head,
//   full (push dropped when set), count occupancy.
module pcie_pay_fifo
  import pcie_tlp_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [31:0]              din,
  input  logic                     rd,
  output logic [31:0]              dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Full uses the occupancy before any same-cycle pop.
  assign full  = count_q == (AW+1)'(DEPTH);
  assign push  = wr && !full;
  assign pop   = rd && (count_q != '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pcie_mwr_tx.sv
// pcie_mwr_tx: posted MWr32 TLP transmitter for the 16-bit ECP3 TX VC0
// port. Payload FIFO in, request (addr,len) in, 3DW header + data out.
// Ports: pay_* FIFO push, req_* request handshake, tx_* core TX,
//   tx_ca_* posted credits. Define PCIE_TX_CREDIT_CHK_EN to gate on
//   credits; otherwise the credit inputs are ignored.
module pcie_mwr_tx
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          pcie_clk,
  input  logic                          sys_rst,
  input  logic [7:0]                    bus_num,
  input  logic [4:0]                    dev_num,
  input  logic [2:0]                    func_num,
  input  logic                          pay_wr,
  input  logic [31:0]                   pay_data,
  output logic                          pay_full,
  output logic [$clog2(FIFO_DEPTH):0]   pay_count,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [29:0]                   req_addr,
  input  logic [LEN_W-1:0]              req_len,
  output logic                          req_err,
  output logic                          busy,
  output logic                          tx_req,
  input  logic                          tx_rdy,
  output logic                          tx_st,
  output logic                          tx_end,
  output logic [15:0]                   tx_data,
  input  logic [8:0]                    tx_ca_ph,
  input  logic [12:0]                   tx_ca_pd,
  input  logic                          tx_ca_p_recheck
);

  tx_state_e        state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      rid_q, rid_d;
  logic [11:0]      idx_q, idx_d;
  logic             tx_req_q, tx_req_d;
  logic             tx_st_q, tx_st_d;
  logic             tx_end_q, tx_end_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic             req_err_q, req_err_d;
  logic             busy_q, busy_d;

  logic        pop, len_ok, accept, credit_ok;
  logic [31:0] head, dw0, dw1, dw2;
  logic [11:0] nidx, last_idx;
  logic [15:0] word;

  pcie_pay_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pcie_clk),
    .rst   (sys_rst),
    .wr    (pay_wr),
    .din   (pay_data),
    .rd    (pop),
    .dout  (head),
    .full  (pay_full),
    .count (pay_count)
  );

`ifdef PCIE_TX_CREDIT_CHK_EN
  assign credit_ok = !tx_ca_p_recheck
    && (tx_ca_ph[8] || tx_ca_ph[7:0] != 8'd0)
    && (tx_ca_pd[12]
        || tx_ca_pd[11:0] >= pd_credits(12'(len_q)));
`else
  logic unused_credit;
  assign unused_credit = ^{tx_ca_ph, tx_ca_pd, tx_ca_p_recheck};
  assign credit_ok = 1'b1;
`endif

  assign len_ok = (req_len != '0) && (32'(req_len) <= MAX_LEN);
  assign req_ready = (state_q == S_IDLE) && len_ok
    && (32'(pay_count) >= 32'(req_len));
  assign accept = req_valid && req_ready;

  assign dw0 = {1'b0, FMT_3DW_DATA, TYPE_MEM, 1'b0, 3'b000,
                4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 10'(len_q)};
  assign dw1 = {rid_q, 8'h00,
                (len_q > LEN_W'(1)) ? 4'hF : 4'h0, 4'hF};
  assign dw2 = {addr_q, 2'b00};

  // Word index: 0..5 header halves, then high/low half per dword.
  assign nidx     = idx_q + 12'd1;
  assign last_idx = 12'd5 + (12'(len_q) << 1);

  always_comb begin
    word = nidx[0] ? head[15:0] : head[31:16];
    unique case (1'b1)
      nidx == 12'd1: word = dw0[15:0];
      nidx == 12'd2: word = dw1[31:16];
      nidx == 12'd3: word = dw1[15:0];
      nidx == 12'd4: word = dw2[31:16];
      nidx == 12'd5: word = dw2[15:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rid_d     = rid_q;
    idx_d     = idx_q;
    tx_req_d  = tx_req_q;
    tx_st_d   = tx_st_q;
    tx_end_d  = tx_end_q;
    tx_data_d = tx_data_q;
    req_err_d = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_err_d = req_valid && !len_ok;
        if (accept) begin
          addr_d  = req_addr;
          len_d   = req_len;
          rid_d   = {bus_num, dev_num, func_num};
          state_d = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (credit_ok) begin
          state_d  = S_REQ;
          tx_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (tx_rdy) begin
          state_d   = S_HDR;
          tx_req_d  = 1'b0;
          tx_st_d   = 1'b1;
          tx_data_d = dw0[31:16];
          idx_d     = '0;
        end
      end
      S_HDR, S_DATA: begin
        if (tx_rdy && tx_end_q) begin
          state_d   = S_IDLE;
          tx_st_d   = 1'b0;
          tx_end_d  = 1'b0;
          tx_data_d = '0;
          idx_d     = '0;
        end else if (tx_rdy) begin
          idx_d     = nidx;
          tx_st_d   = 1'b0;
          tx_data_d = word;
          tx_end_d  = nidx == last_idx;
          if (nidx >= 12'd6) begin
            state_d = S_DATA;
            // Loading the low half frees the head dword, so the
            // next high half already sees the following dword.
            pop     = nidx[0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rid_q     <= '0;
      idx_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_st_q   <= 1'b0;
      tx_end_q  <= 1'b0;
      tx_data_q <= '0;
      req_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rid_q     <= rid_d;
      idx_q     <= idx_d;
      tx_req_q  <= tx_req_d;
      tx_st_q   <= tx_st_d;
      tx_end_q  <= tx_end_d;
      tx_data_q <= tx_data_d;
      req_err_q <= req_err_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_st   = tx_st_q;
  assign tx_end  = tx_end_q;
  assign tx_data = tx_data_q;
  assign req_err = req_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pcie_mwr_tx.sv
// tb_pcie_mwr_tx: scoreboard bench for pcie_mwr_tx; directed cases
// plus randomized requests against a queue-based TLP model.
module tb_pcie_mwr_tx;

  localparam int MAX_LEN = 16;
  localparam int DEPTH   = 32;

  logic        pcie_clk = 0;
  logic        sys_rst = 1;
  logic [7:0]  bus_num = 0;
  logic [4:0]  dev_num = 0;
  logic [2:0]  func_num = 0;
  logic        pay_wr = 0;
  logic [31:0] pay_data = 0;
  logic        pay_full;
  logic [5:0]  pay_count;
  logic        req_valid = 0;
  logic        req_ready;
  logic [29:0] req_addr = 0;
  logic [4:0]  req_len = 0;
  logic        req_err, busy;
  logic        tx_req, tx_st, tx_end;
  logic        tx_rdy = 1;
  logic [15:0] tx_data;
  logic [8:0]  tx_ca_ph = 9'h100;
  logic [12:0] tx_ca_pd = 13'h1000;
  logic        tx_ca_p_recheck = 0;

  pcie_mwr_tx dut (
    .pcie_clk(pcie_clk), .sys_rst(sys_rst),
    .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
    .pay_wr(pay_wr), .pay_data(pay_data),
    .pay_full(pay_full), .pay_count(pay_count),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .req_err(req_err), .busy(busy),
    .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st),
    .tx_end(tx_end), .tx_data(tx_data),
    .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd),
    .tx_ca_p_recheck(tx_ca_p_recheck)
  );

  always #4 pcie_clk = ~pcie_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge pcie_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] payq[$];
  logic [15:0] cur_w[$];
  logic [15:0] cap[$];
  int  mcount = 0;
  int  pos = -1;
  bit  mbusy = 0, have_tlp = 0, err_exp = 0, req_hold = 0;
  bit  rst_chk = 0;
  int  done_cnt = 0;
  int  acc_edge = -1, req_first = -1, st_cyc = -1, end_cyc = -1;

  always @(negedge pcie_clk) begin
    bit push_ok, pop_now, legal, acc, start, adv;
    logic [31:0] w, d;
    if (rst_chk) begin
      rst_chk = 0;
      chk("rst_tx_req", tx_req, 0);
      chk("rst_tx_st", tx_st, 0);
      chk("rst_tx_end", tx_end, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_err", req_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pay_count", pay_count, 0);
    end
    legal = req_len != 0 && req_len <= MAX_LEN;
    chk("pay_count", pay_count, mcount);
    chk("pay_full", pay_full, mcount == DEPTH);
    chk("busy", busy, mbusy);
    chk("req_err", req_err, err_exp);
    chk("req_ready", req_ready, !mbusy && legal && mcount >= req_len);
    if (pos < 0) begin
      chk("tx_st_idle", tx_st, 0);
      chk("tx_end_idle", tx_end, 0);
      chk("tx_req_orphan", tx_req && !have_tlp, 0);
      if (req_hold) chk("tx_req_hold", tx_req, 1);
      if (tx_req && have_tlp && req_first < 0) req_first = cyc;
    end else begin
      chk("tx_req_in_tlp", tx_req, 0);
      chk("tx_st", tx_st, pos == 0);
      chk("tx_end", tx_end, pos == cur_w.size() - 1);
      chk("tx_data", tx_data, cur_w[pos]);
      if (pos == 0 && st_cyc < 0) st_cyc = cyc;
      if (tx_rdy) begin
        cap.push_back(tx_data);
        if (pos == cur_w.size() - 1) end_cyc = cyc;
      end
    end
    if (sys_rst) begin
      payq.delete(); cur_w.delete();
      mcount = 0; pos = -1; mbusy = 0; have_tlp = 0;
      err_exp = 0; req_hold = 0; rst_chk = 1;
    end else begin
      push_ok = pay_wr && mcount < DEPTH;
      pop_now = pos >= 6 && pos % 2 == 0 && tx_rdy;
      acc = !mbusy && req_valid && legal && mcount >= req_len;
      start = pos < 0 && have_tlp && tx_req && tx_rdy;
      adv = pos >= 0 && tx_rdy;
      err_exp = !mbusy && req_valid && !legal;
      req_hold = pos < 0 && tx_req && !tx_rdy;
      if (acc) begin
        cur_w.delete();
        w = 32'h4000_0000 | 32'(req_len);
        cur_w.push_back(w[31:16]); cur_w.push_back(w[15:0]);
        w = {bus_num, dev_num, func_num, 8'h00,
             (req_len > 1) ? 4'hF : 4'h0, 4'hF};
        cur_w.push_back(w[31:16]); cur_w.push_back(w[15:0]);
        w = {req_addr, 2'b00};
        cur_w.push_back(w[31:16]); cur_w.push_back(w[15:0]);
        for (int i = 0; i < req_len; i++) begin
          d = payq.pop_front();
          cur_w.push_back(d[31:16]); cur_w.push_back(d[15:0]);
        end
        mbusy = 1; have_tlp = 1;
        acc_edge = cyc + 1; req_first = -1;
        st_cyc = -1; end_cyc = -1;
      end
      if (start) pos = 0;
      else if (adv) begin
        if (pos == cur_w.size() - 1) begin
          pos = -1; mbusy = 0; have_tlp = 0; done_cnt++;
        end else pos++;
      end
      if (push_ok) begin
        payq.push_back(pay_data);
        mcount++;
      end
      if (pop_now) mcount--;
    end
  end

  task automatic tick();
    @(posedge pcie_clk); #1;
  endtask

  task automatic push(input logic [31:0] d);
    pay_wr = 1; pay_data = d; tick(); pay_wr = 0;
  endtask

  task automatic do_req(input logic [29:0] a, input int len);
    int k = 0;
    req_addr = a; req_len = 5'(len); req_valid = 1;
    while (!mbusy && k < 100) begin tick(); k++; end
    req_valid = 0;
    chk("req_accept", mbusy, 1);
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_cnt == n0 && k < 2000) begin tick(); k++; end
    chk("tlp_done", done_cnt, n0 + 1);
  endtask

  logic [15:0] exp1 [8] = '{16'h4000, 16'h0001, 16'h0200, 16'h000F,
                            16'h1000, 16'h0000, 16'hDEAD, 16'hBEEF};

  initial begin
    int n0, k;
    repeat (3) tick();
    chk("reset_tx_req", tx_req, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_pay_count", pay_count, 0);
    sys_rst = 0;
    tick();

    // 1-DW write
    bus_num = 8'h02;
    push(32'hDEADBEEF);
    cap.delete(); n0 = done_cnt;
    do_req(30'h0400_0000, 1);
    wait_done(n0);
    chk("t1_words", cap.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_word", cap[i], exp1[i]);
    chk("t1_req_latency", req_first - acc_edge, 1);
    chk("t1_end_offset", end_cyc - st_cyc, 7);

    // 16-DW write
    for (int i = 0; i < 16; i++) push($urandom);
    cap.delete(); n0 = done_cnt;
`ifdef PCIE_TX_CREDIT_CHK_EN
    tx_ca_pd = 13'd3;
    do_req(30'h0000_1234, 16);
    repeat (20) tick();
    chk("t2_credit_req", tx_req, 0);
    chk("t2_credit_busy", busy, 1);
    tx_ca_pd = 13'd4;
`else
    do_req(30'h0000_1234, 16);
`endif
    wait_done(n0);
    chk("t2_words", cap.size(), 38);
    chk("t2_len_field", cap[1], 16'h0010);
    chk("t2_rid", cap[2], 16'h0200);
    chk("t2_be", cap[3], 16'h00FF);
    tx_ca_pd = 13'h1000;

`ifdef PCIE_TX_CREDIT_CHK_EN
    // recheck holds off tx_req
    push($urandom); push($urandom);
    n0 = done_cnt;
    tx_ca_p_recheck = 1;
    do_req(30'h0000_0010, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t3_recheck_req", tx_req, 0);
      tick();
    end
    tx_ca_p_recheck = 0;
    chk("t3_drop_req", tx_req, 0);
    tick();
    chk("t3_after_req", tx_req, 1);
    wait_done(n0);
`endif

    // stall at data word 4
    for (int i = 0; i < 8; i++) push($urandom);
    cap.delete(); n0 = done_cnt;
    do_req(30'h2000_0000, 8);
    k = 0;
    while (pos != 10 && k < 100) begin tick(); k++; end
    chk("t4_reach_word", pos, 10);
    tx_rdy = 0;
    repeat (3) tick();
    tx_rdy = 1;
    wait_done(n0);
    chk("t4_words", cap.size(), 22);
    chk("t4_end_offset", end_cyc - st_cyc, 24);

    // illegal length, then insufficient payload
    req_len = 0; req_valid = 1;
    tick();
    req_valid = 0;
    chk("t5_err_pulse", req_err, 1);
    tick();
    chk("t5_err_clear", req_err, 0);
    push(1); push(2); push(3);
    n0 = done_cnt;
    req_len = 5; req_valid = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_not_ready", req_ready, 0);
      tick();
    end
    push(4); push(5);
    #1;
    chk("t5_ready", req_ready, 1);
    do_req(30'h0000_0100, 5);
    wait_done(n0);

    // reset mid-DATA
    for (int i = 0; i < 8; i++) push($urandom);
    do_req(30'h0000_0200, 8);
    k = 0;
    while (pos < 8 && k < 100) begin tick(); k++; end
    sys_rst = 1;
    tick();
    sys_rst = 0;
    chk("t6_tx_req", tx_req, 0);
    chk("t6_tx_st", tx_st, 0);
    chk("t6_tx_end", tx_end, 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pay_count", pay_count, 0);
    tick();

    // FIFO full
    pay_wr = 1;
    for (int i = 0; i < 33; i++) begin
      pay_data = $urandom; tick();
    end
    pay_wr = 0;
    chk("t6_full", pay_full, 1);
    chk("t6_count", pay_count, 32);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int len, np;
      len = $urandom_range(0, 20);
      np = $urandom_range(0, 6);
      for (int i = 0; i < np; i++) push($urandom);
      req_addr = 30'($urandom);
      req_len = 5'(len); req_valid = 1;
      if (len == 0 || len > MAX_LEN) begin
        tick(); req_valid = 0; tick();
      end else begin
        k = 0;
        while (!mbusy && k < 200) begin
          pay_wr = 1'($urandom_range(0, 1));
          pay_data = $urandom;
          tx_rdy = ($urandom_range(0, 3) != 0);
          tick(); k++;
        end
        req_valid = 0;
        chk("rnd_accept", mbusy, 1);
        k = 0;
        while (mbusy && k < 1000) begin
          pay_wr = 1'($urandom_range(0, 1));
          pay_data = $urandom;
          tx_rdy = ($urandom_range(0, 3) != 0);
          tick(); k++;
        end
        pay_wr = 0; tx_rdy = 1;
        chk("rnd_done", mbusy, 0);
      end
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
